// File: rtl/wbdbgbus_cmd_assembler.sv
// Gathers five UART bytes into one 36-bit debug-bus command {opcode, payload}.
// The result goes out on a valid/ready port. A partial frame is dropped after an inter-byte timeout.
module wbdbgbus_cmd_assembler #(
  parameter int TIMEOUT_CLKS = 2500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic [35:0] o_cmd_data,
  output logic        o_cmd_valid,
  input  logic        i_cmd_ready,
  output logic        o_overflow,
  output logic        o_timeout
);

  localparam int TW = $clog2(TIMEOUT_CLKS);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  // Opcode plus the first three payload bytes.
  // The last byte goes straight into the output register.
  logic [35:8]   asm_q, asm_d;
  logic          done, expire, load;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    asm_d   = asm_q;
    done    = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (i_valid) begin
          asm_d[35:32] = i_data[3:0];
          cnt_d        = 3'd1;
          state_d      = COLLECT;
        end
      end
      COLLECT: begin
        // An arriving byte takes priority over timer expiry.
        if (i_valid) begin
          tmr_d = '0;
          case (cnt_q)
            3'd1:    asm_d[31:24] = i_data;
            3'd2:    asm_d[23:16] = i_data;
            3'd3:    asm_d[15:8]  = i_data;
            default: done = 1'b1;
          endcase
          if (done) begin
            cnt_d   = 3'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end else if (tmr_q == TW'(TIMEOUT_CLKS - 1)) begin
          expire  = 1'b1;
          cnt_d   = 3'd0;
          tmr_d   = '0;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A same-cycle handshake on the held word frees the slot for the new one.
  assign load = done && (!o_cmd_valid || i_cmd_ready);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      tmr_q       <= '0;
      asm_q       <= '0;
      o_cmd_data  <= '0;
      o_cmd_valid <= 1'b0;
      o_overflow  <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      asm_q      <= asm_d;
      o_overflow <= done && !load;
      o_timeout  <= expire;
      if (load) begin
        o_cmd_data  <= {asm_q, i_data};
        o_cmd_valid <= 1'b1;
      end else if (i_cmd_ready) begin
        o_cmd_valid <= 1'b0;
      end
    end
  end

endmodule
